vsd_sar_adc_ctrl: RTL and testbench
===================================

# vsd_sar_adc_ctrl

Successive-approximation ADC controller: the capture direction of the SoC's existing 10-bit DAC path. It reuses a 10-bit DAC plus an external analog comparator, binary-searches the input voltage, and hands the resulting code to the `rvmyth` side over a valid/ready interface. It runs on the PLL clock `CLK`, in the same domain as the core.

## Interface
- `WIDTH`, default 10: conversion resolution; also the DAC code width.
- `SETTLE_CYCLES`, default 2, range 0..15: cycles the DAC is given to settle after each trial code before the comparator is sampled.

Ports:
- `CLK`  in  1  PLL clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a conversion; level, sampled on the edge.
- `cmp`  in  1  comparator output; 1 means the analog input is at or above the DAC output.
- `dac_code`  out  WIDTH  trial code driven to the DAC input.
- `busy`  out  1  high while a conversion is in progress; also serves as the sample-and-hold "hold" control.
- `result`  out  WIDTH  converted code, valid when `valid`=1.
- `valid`  out  1  result available.
- `ready`  in  1  consumer accepts the result.

## Operation
- States:
  - IDLE: waits for `start`.
  - SETTLE: counts `SETTLE_CYCLES` cycles after each trial code; skipped when the parameter is 0.
  - DECIDE: samples `cmp` for the current bit.
  - DONE: holds the result until it is taken.
- IDLE with `start`=1 at an edge: moves to SETTLE, or directly to DECIDE when `SETTLE_CYCLES`=0.
  - Bit index becomes WIDTH-1.
  - Accumulator `acc` is cleared.
  - `dac_code` becomes 1<<(WIDTH-1).
- Trial code: `dac_code` = `acc` | (1<<i) throughout SETTLE and DECIDE for bit i.
- DECIDE edge for bit i:
  - If `cmp`=1, bit i of `acc` is set; otherwise it stays 0.
  - If i>0: decrement i and return to SETTLE (or stay in DECIDE when `SETTLE_CYCLES`=0).
  - If i=0: go to DONE, latch `result`=`acc` including the final bit, and set `valid`=1.
- DONE:
  - `dac_code` = `result`.
  - `valid`=1 and `result` stay stable until an edge with `ready`=1.
  - On `valid`&&`ready`: if `start`=1 on the same edge, start a new conversion directly (back-to-back); otherwise go to IDLE and clear `valid`.
- `start` is ignored while `busy`=1 and while in DONE without `ready`; no request queuing.
- IDLE: `dac_code` and `result` hold their last values.
- `busy`=1 exactly in SETTLE and DECIDE.
- Reset values: `dac_code`=0, `result`=0, `valid`=0, `busy`=0, state IDLE, settle counter 0.
- Reset mid-conversion or in DONE aborts the operation; the pending result is discarded and no `valid` pulse appears.

## Timing
- Per bit: `SETTLE_CYCLES`+1 cycles.
- Latency, counted from the edge that accepts `start` to the first cycle with `valid`=1: WIDTH*(`SETTLE_CYCLES`+1) cycles. With defaults this is 30.
- `cmp` is sampled only on the final edge of DECIDE. It must reflect the `dac_code` that has been stable for `SETTLE_CYCLES`+1 cycles.
- `busy` rises on the accept edge and falls on the edge that enters DONE.
- Back-to-back conversions: the handshake edge is also the new accept edge, so `valid` drops and `busy` rises on the same edge. Throughput is one result per WIDTH*(`SETTLE_CYCLES`+1) cycles.
- All outputs are registered; there is no combinational path from `cmp`, `start` or `ready` to any output.

## Structure
- Shared package `vsd_sar_pkg`:
  - state enum (IDLE, SETTLE, DECIDE, DONE);
  - `SAR_WIDTH_DEFAULT`=10;
  - `SAR_SETTLE_DEFAULT`=2.
- Sub-module `vsd_sar_settle_timer`: a load/count-down counter of 4 bits with a `done` output. It is instantiated only when `SETTLE_CYCLES`>0.
- Bit index width: $clog2(WIDTH).
- Trial mask: a one-hot shift register, shifted right once per DECIDE edge.

## Test plan
The bench comparator model is `cmp` = (VIN_CODE >= `dac_code`).
- VIN_CODE=0x2A5, `start` pulsed, `ready`=1 -> `valid` rises 30 cycles after the accept edge with `result`=0x2A5. Trial sequence 0x200, 0x300, 0x280, 0x2C0, 0x2A0, ...
- VIN_CODE=0x000 and then 0x3FF -> results 0x000 and 0x3FF. First trial code 0x200 in both cases, `busy` high for exactly 30 cycles.
- VIN_CODE=0x155, `ready` held low for 8 cycles after `valid` -> `valid`=1, `result`=0x155 and `dac_code`=0x155 stable throughout; single transfer on the `ready` edge.
- `start` pulsed again at cycle 10 of a conversion -> ignored; exactly one result. `start` held high with `ready`=1 -> back-to-back results every 30 cycles with no idle cycle.
- `reset` asserted at cycle 12 of a conversion -> next edge shows `dac_code`=0, `busy`=0, `valid`=0, `result`=0. A subsequent conversion with VIN_CODE=0x0F0 yields 0x0F0.
- `SETTLE_CYCLES`=0 build, VIN_CODE=0x3A7 -> `result`=0x3A7 after 10 cycles.

Source files
------------

// File: rtl/vsd_sar_pkg.sv
// Shared types and defaults for the SAR ADC controller.
package vsd_sar_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, DONE} sar_state_e;
  localparam int SAR_WIDTH_DEFAULT  = 10;
  localparam int SAR_SETTLE_DEFAULT = 2;
endpackage

// File: rtl/vsd_sar_settle_timer.sv
// Loadable 4-bit down-counter; done while the count is zero.
module vsd_sar_settle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (en && cnt_q != '0) cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/vsd_sar_adc_ctrl.sv
// SAR ADC controller: binary search over a DAC code using an external comparator,
// result delivered over valid/ready.
module vsd_sar_adc_ctrl
  import vsd_sar_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH_DEFAULT,
  parameter int SETTLE_CYCLES = SAR_SETTLE_DEFAULT
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             cmp,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  input  logic             ready
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam sar_state_e TRIAL_ST = (SETTLE_CYCLES > 0) ? SETTLE : DECIDE;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d, mask_q, mask_d, dac_q, dac_d, result_q, result_d;
  logic             busy_q, busy_d, valid_q, valid_d;
  logic [WIDTH-1:0] acc_nxt;
  logic             accept, settle_load, settle_done;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    mask_d      = mask_q;
    dac_d       = dac_q;
    result_d    = result_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    accept      = 1'b0;
    settle_load = 1'b0;
    acc_nxt     = acc_q | (cmp ? mask_q : '0);
    case (state_q)
      IDLE:   if (start) accept = 1'b1;
      SETTLE: if (settle_done) state_d = DECIDE;
      DECIDE: begin
        acc_d = acc_nxt;
        if (idx_q != '0) begin
          idx_d       = idx_q - 1'b1;
          mask_d      = mask_q >> 1;
          dac_d       = acc_nxt | (mask_q >> 1);
          state_d     = TRIAL_ST;
          settle_load = 1'b1;
        end else begin
          result_d = acc_nxt;
          dac_d    = acc_nxt;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: if (ready) begin
        if (start) accept = 1'b1;
        else begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake edge doubles as the accept edge for back-to-back conversions.
    if (accept) begin
      state_d     = TRIAL_ST;
      idx_d       = IW'(WIDTH-1);
      acc_d       = '0;
      mask_d      = MSB_MASK;
      dac_d       = MSB_MASK;
      busy_d      = 1'b1;
      valid_d     = 1'b0;
      settle_load = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      mask_q   <= '0;
      dac_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  generate
    if (SETTLE_CYCLES > 0) begin : g_settle
      // Loaded with N-1 so SETTLE lasts exactly N cycles before DECIDE.
      vsd_sar_settle_timer u_timer (
        .clk      (CLK),
        .reset    (reset),
        .load     (settle_load),
        .load_val (4'(SETTLE_CYCLES-1)),
        .en       (state_q == SETTLE),
        .done     (settle_done)
      );
    end else begin : g_nosettle
      logic unused_settle_load;
      assign unused_settle_load = settle_load;
      assign settle_done        = 1'b1;
    end
  endgenerate

  assign dac_code = dac_q;
  assign result   = result_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
endmodule

// File: tb/tb_vsd_sar_adc_ctrl.sv
// Random and directed checks of the SAR controller against an ideal-comparator model.
module tb_vsd_sar_adc_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, ready, sel;
  logic [9:0] vin;
  logic       start2, start0, cmp2, cmp0;
  logic [9:0] dac2, dac0, res2, res0;
  logic       busy2, busy0, valid2, valid0;
  logic [9:0] dac, res;
  logic       busy, valid;
  int n_chk = 0, n_err = 0;

  // sel=0 exercises the default build, sel=1 the no-settle build
  assign start2 = start & ~sel;
  assign start0 = start & sel;
  assign cmp2   = (vin >= dac2);
  assign cmp0   = (vin >= dac0);
  assign dac    = sel ? dac0 : dac2;
  assign res    = sel ? res0 : res2;
  assign busy   = sel ? busy0 : busy2;
  assign valid  = sel ? valid0 : valid2;

  vsd_sar_adc_ctrl u_dut (
    .CLK(clk), .reset(reset), .start(start2), .cmp(cmp2), .dac_code(dac2),
    .busy(busy2), .result(res2), .valid(valid2), .ready(ready));

  vsd_sar_adc_ctrl #(.WIDTH(10), .SETTLE_CYCLES(0)) u_dut0 (
    .CLK(clk), .reset(reset), .start(start0), .cmp(cmp0), .dac_code(dac0),
    .busy(busy0), .result(res0), .valid(valid0), .ready(ready));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Trial code for bit i of a binary search towards v: bits above i of v, plus bit i.
  function automatic int trial(input int v, input int i);
    return ((v >> (i + 1)) << (i + 1)) | (1 << i);
  endfunction

  function automatic int per_bit();
    return sel ? 1 : 3;
  endfunction

  task automatic check_conv(input int v, input bit mid);
    int spb, lat;
    spb = per_bit();
    lat = 10 * spb;
    for (int n = 1; n <= lat; n++) begin
      if (n > 1) @(negedge clk);
      start = (mid && n == 10);
      chk("busy", busy, 1);
      chk("valid_lo", valid, 0);
      chk("trial", dac, trial(v, 9 - (n - 1) / spb));
    end
  endtask

  task automatic run_conv(input int v, input int rd, input bit mid);
    vin = v[9:0];
    @(negedge clk); start = 1'b1; ready = 1'b0;
    @(negedge clk); start = 1'b0;
    check_conv(v, mid);
    for (int h = 0; h <= rd; h++) begin
      @(negedge clk);
      start = 1'b0;
      chk("valid", valid, 1);
      chk("busy_done", busy, 0);
      chk("result", res, v);
      chk("dac_done", dac, v);
      if (h == rd) ready = 1'b1;
    end
    @(negedge clk); ready = 1'b0;
    chk("valid_clr", valid, 0);
    chk("busy_idle", busy, 0);
    chk("result_hold", res, v);
    chk("dac_hold", dac, v);
  endtask

  task automatic run_b2b(input int cnt);
    int v;
    sel = 1'b0;
    v = $urandom_range(0, 1023);
    vin = v[9:0];
    @(negedge clk); start = 1'b1; ready = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      @(negedge clk);
      for (int n = 1; n <= 30; n++) begin
        if (n > 1) @(negedge clk);
        chk("b2b_busy", busy, 1);
        chk("b2b_valid_lo", valid, 0);
        chk("b2b_trial", dac, trial(v, 9 - (n - 1) / 3));
      end
      @(negedge clk);
      chk("b2b_valid", valid, 1);
      chk("b2b_busy_lo", busy, 0);
      chk("b2b_result", res, v);
      v = $urandom_range(0, 1023);
      vin = v[9:0];
      if (k == cnt - 1) start = 1'b0;
    end
    @(negedge clk); ready = 1'b0;
    chk("b2b_end_valid", valid, 0);
    chk("b2b_end_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ready = 1'b0; sel = 1'b0; vin = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_dac", dac, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      chk("rst_result", res, 0);
    end
    sel = 1'b0;
    @(negedge clk); reset = 1'b0;

    run_conv(10'h2A5, 0, 0);
    run_conv(10'h000, 0, 0);
    run_conv(10'h3FF, 0, 0);
    run_conv(10'h155, 8, 0);
    run_conv(10'h2A5, 0, 1);
    run_b2b(3);

    // Abort mid-conversion
    vin = 10'h2A5;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort_dac", dac, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_result", res, 0);
    for (int n = 0; n < 35; n++) begin
      @(negedge clk);
      chk("abort_no_valid", valid, 0);
    end
    run_conv(10'h0F0, 0, 0);

    sel = 1'b1;
    run_conv(10'h3A7, 0, 0);
    run_conv(10'h001, 2, 1);

    repeat (8) begin
      sel = 1'($urandom_range(0, 1));
      run_conv($urandom_range(0, 1023), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
